// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states,
// common host command bytes and the host frame length.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RX,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_REL
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    localparam int PS2_TX_BITS = 10;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 lines plus
// falling-edge detect on the clock line.
module ps2_line_sync (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Resetn,
    input  logic line_clk,
    input  logic line_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle lines are high, so reset to 1 to avoid a false edge.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], line_clk};
            data_ff  <= {data_ff[0], line_data};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 10 bits, ACK).
// Define PS2_TX_RETRY_EN to resend once after a NACK or timeout.
module ps2_host_tx_ctrl
    import ps2_pkg::*;
#(
    parameter int C_INHIBIT_CYCLES = 10000,
    parameter int C_TIMEOUT_CYCLES = 1500000,
    parameter int C_CNT_W          = 21
) (
    input  logic       Bus2IP_Clk,
    input  logic       Bus2IP_Resetn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       rx_busy,
    output logic       rx_hold,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam logic [C_CNT_W-1:0] INH_LAST = C_CNT_W'(C_INHIBIT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] TMO_CNT  = C_CNT_W'(C_TIMEOUT_CYCLES);
    localparam logic [3:0]         LAST_IDX = 4'(PS2_TX_BITS - 1);

    ps2_tx_state_t      state, state_n;
    logic [C_CNT_W-1:0] cnt, cnt_n;
    logic [3:0]         bit_idx, idx_n;
    logic [7:0]         shreg, shreg_n;
    logic               parity, par_n;
    logic               data_q, data_n;
    logic               clk_s, data_s, clk_fall;
    logic               in_wd, nack, tmo;
`ifdef PS2_TX_RETRY_EN
    logic               retry_q, retry_n;
`endif

    ps2_line_sync u_sync (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Resetn (Bus2IP_Resetn),
        .line_clk      (ps2_clk_i),
        .line_data     (ps2_data_i),
        .clk_sync      (clk_s),
        .data_sync     (data_s),
        .clk_fall      (clk_fall)
    );

    // State, shared cycle counter and frame registers.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            data_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= idx_n;
            shreg   <= shreg_n;
            parity  <= par_n;
            data_q  <= data_n;
`ifdef PS2_TX_RETRY_EN
            retry_q <= retry_n;
`endif
        end
    end

    // Next-state, line drive and status pulses.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = bit_idx;
        shreg_n     = shreg;
        par_n       = parity;
        data_n      = data_q;
        cmd_ready   = 1'b0;
        tx_done     = 1'b0;
        err_nack    = 1'b0;
        err_timeout = 1'b0;
        nack        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_n     = retry_q;
`endif
        in_wd = (state == RTS) || (state == SHIFT) ||
                (state == ACK) || (state == WAIT_REL);
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                data_n    = 1'b0;
                cnt_n     = '0;
                if (cmd_valid) begin
                    shreg_n = cmd_data;
                    par_n   = ~^cmd_data;
                    state_n = rx_busy ? WAIT_RX : INHIBIT;
                end
            end
            WAIT_RX: begin
                if (!rx_busy) begin
                    state_n = INHIBIT;
                    cnt_n   = '0;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n = RTS;
                    cnt_n   = '0;
                    data_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RTS: begin
                cnt_n   = cnt + 1'b1;
                idx_n   = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                cnt_n = cnt + 1'b1;
                if (clk_fall) begin
                    idx_n = bit_idx + 1'b1;
                    if (bit_idx < 4'd8) begin
                        data_n = ~shreg[bit_idx[2:0]];
                    end else if (bit_idx != LAST_IDX) begin
                        data_n = ~parity;
                    end else begin
                        data_n  = 1'b0;
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                cnt_n = cnt + 1'b1;
                if (clk_fall) begin
                    if (data_s) nack = 1'b1;
                    else        state_n = WAIT_REL;
                end
            end
            WAIT_REL: begin
                cnt_n = cnt + 1'b1;
                if (clk_s && data_s) begin
                    tx_done = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Watchdog wins over any edge seen in the same cycle.
        tmo = in_wd && (cnt == TMO_CNT);
        if (tmo) begin
            tx_done = 1'b0;
            nack    = 1'b0;
        end
        if (tmo || nack) begin
            data_n  = 1'b0;
            state_n = IDLE;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_n = 1'b1;
                state_n = INHIBIT;
                cnt_n   = '0;
            end else begin
                err_timeout = tmo;
                err_nack    = nack;
            end
`else
            err_timeout = tmo;
            err_nack    = nack;
`endif
        end
`ifdef PS2_TX_RETRY_EN
        if (state_n == IDLE) retry_n = 1'b0;
`endif
    end

    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = data_q | ((state == INHIBIT) && (cnt == INH_LAST));
    assign rx_hold     = (state != IDLE) && (state != WAIT_RX);

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Directed bench for ps2_host_tx_ctrl with an open-drain
// device model; expectations follow PS2_TX_RETRY_EN if defined.
module tb_ps2_host_tx_ctrl;

    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int HALF = 40;

    logic       Bus2IP_Clk = 1'b0;
    logic       Bus2IP_Resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rx_busy = 1'b0;
    logic       rx_hold;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_done, err_nack, err_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_nack = 0;
    int n_tmo = 0;

    assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_i = ~ps2_data_oe & dev_data;

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    ps2_host_tx_ctrl #(
        .C_INHIBIT_CYCLES (INH),
        .C_TIMEOUT_CYCLES (TMO),
        .C_CNT_W          (21)
    ) dut (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Resetn (Bus2IP_Resetn),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .rx_busy       (rx_busy),
        .rx_hold       (rx_hold),
        .ps2_clk_i     (ps2_clk_i),
        .ps2_data_i    (ps2_data_i),
        .ps2_clk_oe    (ps2_clk_oe),
        .ps2_data_oe   (ps2_data_oe),
        .tx_done       (tx_done),
        .err_nack      (err_nack),
        .err_timeout   (err_timeout)
    );

    always @(negedge Bus2IP_Clk) begin
        if (tx_done)     n_done++;
        if (err_nack)    n_nack++;
        if (err_timeout) n_tmo++;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Bus2IP_Clk);
    endtask

    task automatic clear_counts();
        tick();
        n_done = 0;
        n_nack = 0;
        n_tmo  = 0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check_eq("ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        check_eq("ready_drop", cmd_ready, 0);
    endtask

    task automatic measure_inhibit(output int len, output int dfirst,
                                   output logic d_rts);
        int n = 0;
        len    = 0;
        dfirst = -1;
        d_rts  = 1'b0;
        while (!ps2_clk_oe && n < 20000) begin
            tick();
            n++;
        end
        if (!ps2_clk_oe) begin
            check_eq("inhibit_start", ps2_clk_oe, 1);
            return;
        end
        while (ps2_clk_oe && len < 20000) begin
            if (ps2_data_oe && dfirst < 0) dfirst = len;
            len++;
            tick();
        end
        d_rts = ps2_data_oe;
        check_eq("hold_in_rts", rx_hold, 1);
    endtask

    task automatic dev_clock(input logic ack, input int abort_edge,
                             output logic [10:0] frame);
        frame = '0;
        for (int e = 1; e <= 11; e++) begin
            for (int c = 0; c < HALF; c++) begin
                if (c == HALF / 2) frame[e-1] = ps2_data_i;
                if (e == 11 && c == (HALF * 3) / 4) dev_data = ack;
                tick();
            end
            dev_clk = 1'b0;
            if (e == abort_edge) begin
                repeat (5) tick();
                return;
            end
            repeat (HALF) tick();
            dev_clk = 1'b1;
        end
        repeat (10) tick();
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check_eq("ready_back", cmd_ready, 1);
        repeat (2) tick();
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [10:0] exp,
                             input int busy);
        int len, dfirst, seen;
        logic d_rts;
        logic [10:0] fr;
        clear_counts();
        if (busy > 0) rx_busy = 1'b1;
        send_cmd(b);
        if (busy > 0) begin
            seen = 0;
            for (int i = 0; i < busy; i++) begin
                if (ps2_clk_oe || rx_hold || cmd_ready) seen = 1;
                tick();
            end
            check_eq("rx_wait_quiet", seen, 0);
            rx_busy = 1'b0;
        end
        measure_inhibit(len, dfirst, d_rts);
        check_eq("inhibit_len", len, INH);
        check_eq("data_oe_rise", dfirst, INH - 1);
        check_eq("rts_start_bit", d_rts, 1);
        dev_clock(1'b0, 0, fr);
        check_eq("frame_bits", fr, exp);
        wait_idle();
        check_eq("done_cnt", n_done, 1);
        check_eq("nack_cnt", n_nack, 0);
        check_eq("tmo_cnt", n_tmo, 0);
    endtask

    initial begin
        int len, dfirst, n;
        logic d_rts;
        logic [10:0] fr;

        repeat (3) tick();
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe, rx_hold}, 0);
        check_eq("rst_pulses", {tx_done, err_nack, err_timeout}, 0);
        Bus2IP_Resetn = 1'b1;
        repeat (3) tick();

        run_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 0);
        run_frame(8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 0);
        run_frame(8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 0);
        run_frame(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 500);

        clear_counts();
        send_cmd(8'hF4);
        measure_inhibit(len, dfirst, d_rts);
        n = 0;
        while (!err_timeout && !ps2_clk_oe && n < TMO + 100) begin
            tick();
            n++;
        end
`ifdef PS2_TX_RETRY_EN
        check_eq("retry_reinhibit_at", n, TMO + 1);
        check_eq("retry_no_err", n_tmo, 0);
        measure_inhibit(len, dfirst, d_rts);
        check_eq("retry_inhibit_len", len, INH);
        n = 0;
        while (!err_timeout && !ps2_clk_oe && n < TMO + 100) begin
            tick();
            n++;
        end
`endif
        check_eq("tmo_at", n, TMO);
        check_eq("tmo_pulse", err_timeout, 1);
        tick();
        check_eq("tmo_oe_off", {ps2_clk_oe, ps2_data_oe}, 0);
        wait_idle();
        check_eq("tmo_cnt", n_tmo, 1);
        check_eq("tmo_done_cnt", n_done + n_nack, 0);

        clear_counts();
        send_cmd(8'hED);
        measure_inhibit(len, dfirst, d_rts);
        dev_clock(1'b1, 0, fr);
`ifdef PS2_TX_RETRY_EN
        check_eq("nack_retry_quiet", n_nack, 0);
        measure_inhibit(len, dfirst, d_rts);
        dev_clock(1'b1, 0, fr);
`endif
        wait_idle();
        check_eq("nack_cnt", n_nack, 1);
        check_eq("nack_done_cnt", n_done + n_tmo, 0);

        clear_counts();
        send_cmd(8'h00);
        measure_inhibit(len, dfirst, d_rts);
        dev_clock(1'b0, 5, fr);
        check_eq("abort_pre_data_oe", ps2_data_oe, 1);
        Bus2IP_Resetn = 1'b0;
        #1;
        check_eq("abort_oe_off", {ps2_clk_oe, ps2_data_oe}, 0);
        check_eq("abort_ready", cmd_ready, 1);
        dev_clk = 1'b1;
        repeat (5) tick();
        Bus2IP_Resetn = 1'b1;
        repeat (3) tick();
        check_eq("abort_no_pulse", n_done + n_nack + n_tmo, 0);
        run_frame(8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
